// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 decryption sequencer.
package aes_pkg;

    // Sequencer states: key expansion, message load, then the inverse-cipher step loop.
    typedef enum logic [3:0] {
        IDLE,
        KEY_EXP,
        LOAD,
        ARK_INIT,
        SHIFT,
        SUB,
        ARK,
        MIX,
        DONE
    } state_t;

    // Datapath state-register input mux selects.
    localparam logic [2:0] SEL_HOLD      = 3'd0;
    localparam logic [2:0] SEL_LOAD_MSG  = 3'd1;
    localparam logic [2:0] SEL_ADD_RK    = 3'd2;
    localparam logic [2:0] SEL_INV_SHIFT = 3'd3;
    localparam logic [2:0] SEL_INV_SUB   = 3'd4;
    localparam logic [2:0] SEL_INV_MIX   = 3'd5;

    localparam int AES128_ROUNDS = 10;

endpackage

// File: rtl/aes_decrypt_ctrl.sv
// Sequencing FSM for the AES-128 decryption datapath. Drives mux selects and load
// strobes only; key expansion latency, round count and InvMixColumns column are
// tracked by small counters held beside the state register.
module aes_decrypt_ctrl
    import aes_pkg::*;
#(
    parameter int KEYEXP_CYCLES = 12,
    parameter int NUM_ROUNDS    = AES128_ROUNDS
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       AES_START,
    output logic       AES_DONE,
    output logic       BUSY,
    output logic       KEYEXP_START,
    output logic [2:0] STATE_SEL,
    output logic       STATE_LD,
    output logic [3:0] RK_IDX,
    output logic [1:0] IMC_WORD
);

    localparam int            KW        = $clog2(KEYEXP_CYCLES + 1);
    localparam logic [KW-1:0] KEXP_LAST = KW'(KEYEXP_CYCLES - 1);
    localparam logic [3:0]    ROUND_TOP = 4'(NUM_ROUNDS);

    state_t        state, state_nxt;
    logic [KW-1:0] kexp_cnt, kexp_nxt;
    logic [3:0]    round_cnt, round_nxt;
    logic [1:0]    word_cnt, word_nxt;
    logic          busy_state;

    // State register and counters; synchronous reset returns everything to IDLE/0.
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            kexp_cnt  <= '0;
            round_cnt <= '0;
            word_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            kexp_cnt  <= kexp_nxt;
            round_cnt <= round_nxt;
            word_cnt  <= word_nxt;
        end
    end

    assign busy_state = (state != IDLE) && (state != DONE);

    // Next-state and counter updates, with abort on START dropping while busy.
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        kexp_nxt  = kexp_cnt;
        round_nxt = round_cnt;
        word_nxt  = word_cnt;
        unique case (state)
            IDLE: begin
                if (AES_START) begin
                    state_nxt = KEY_EXP;
                    kexp_nxt  = KEXP_LAST;
                end
            end
            KEY_EXP: begin
                if (kexp_cnt == '0) state_nxt = LOAD;
                else                kexp_nxt  = kexp_cnt - KW'(1);
            end
            LOAD:     state_nxt = ARK_INIT;
            ARK_INIT: begin
                round_nxt = ROUND_TOP - 4'd1;
                state_nxt = SHIFT;
            end
            SHIFT:    state_nxt = SUB;
            SUB:      state_nxt = ARK;
            ARK: begin
                // The last round has no InvMixColumns step.
                if (round_cnt == 4'd0) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = MIX;
                    word_nxt  = 2'd0;
                end
            end
            MIX: begin
                if (word_cnt == 2'd3) begin
                    word_nxt  = 2'd0;
                    round_nxt = round_cnt - 4'd1;
                    state_nxt = SHIFT;
                end else begin
                    word_nxt  = word_cnt + 2'd1;
                end
            end
            DONE: begin
                // Holding START after completion never restarts; it must drop first.
                if (!AES_START) state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
        if (busy_state && !AES_START) begin
            state_nxt = IDLE;
            kexp_nxt  = '0;
            round_nxt = '0;
            word_nxt  = '0;
        end
    end

    // Moore output decode from the state register and counters.
    always_comb begin
        AES_DONE     = 1'b0;
        BUSY         = busy_state;
        KEYEXP_START = 1'b0;
        STATE_SEL    = SEL_HOLD;
        STATE_LD     = 1'b0;
        RK_IDX       = 4'd0;
        IMC_WORD     = 2'd0;
        unique case (state)
            KEY_EXP:  KEYEXP_START = (kexp_cnt == KEXP_LAST);
            LOAD: begin
                STATE_SEL = SEL_LOAD_MSG;
                STATE_LD  = 1'b1;
            end
            ARK_INIT: begin
                STATE_SEL = SEL_ADD_RK;
                STATE_LD  = 1'b1;
                RK_IDX    = ROUND_TOP;
            end
            SHIFT: begin
                STATE_SEL = SEL_INV_SHIFT;
                STATE_LD  = 1'b1;
            end
            SUB: begin
                STATE_SEL = SEL_INV_SUB;
                STATE_LD  = 1'b1;
            end
            ARK: begin
                STATE_SEL = SEL_ADD_RK;
                STATE_LD  = 1'b1;
                RK_IDX    = round_cnt;
            end
            MIX: begin
                STATE_SEL = SEL_INV_MIX;
                STATE_LD  = 1'b1;
                IMC_WORD  = word_cnt;
            end
            DONE:     AES_DONE = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Self-checking bench for aes_decrypt_ctrl: two instances (key-expansion latency 12
// and 1) share clock, reset and START; every cycle of every run is compared with a
// schedule computed arithmetically from cycle offset since START.
module tb_aes_decrypt_ctrl;

    localparam int KA = 12;
    localparam int KB = 1;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       start;
    logic       done_a, busy_a, kst_a, ld_a;
    logic [2:0] sel_a;
    logic [3:0] rk_a;
    logic [1:0] imc_a;
    logic       done_b, busy_b, kst_b, ld_b;
    logic [2:0] sel_b;
    logic [3:0] rk_b;
    logic [1:0] imc_b;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    aes_decrypt_ctrl #(.KEYEXP_CYCLES(KA), .NUM_ROUNDS(10)) dut_a (
        .CLK(CLK), .RESET(RESET), .AES_START(start), .AES_DONE(done_a), .BUSY(busy_a),
        .KEYEXP_START(kst_a), .STATE_SEL(sel_a), .STATE_LD(ld_a), .RK_IDX(rk_a),
        .IMC_WORD(imc_a)
    );

    aes_decrypt_ctrl #(.KEYEXP_CYCLES(KB), .NUM_ROUNDS(10)) dut_b (
        .CLK(CLK), .RESET(RESET), .AES_START(start), .AES_DONE(done_b), .BUSY(busy_b),
        .KEYEXP_START(kst_b), .STATE_SEL(sel_b), .STATE_LD(ld_b), .RK_IDX(rk_b),
        .IMC_WORD(imc_b)
    );

    // Output bundle: {done, busy, keyexp_start, sel[2:0], ld, rk[3:0], imc[1:0]}.
    wire [12:0] obs_a = {done_a, busy_a, kst_a, sel_a, ld_a, rk_a, imc_a};
    wire [12:0] obs_b = {done_b, busy_b, kst_b, sel_b, ld_b, rk_b, imc_b};

    function automatic logic [12:0] mk(input logic d, input logic b, input logic ks,
                                       input int sel, input logic ld, input int rk,
                                       input int imc);
        return {d, b, ks, 3'(sel), ld, 4'(rk), 2'(imc)};
    endfunction

    // Expected outputs t cycles after START was sampled high in IDLE (t=0).
    function automatic logic [12:0] expect_at(input int k, input int t);
        int u, r, p;
        if (t <= 0) return 13'd0;
        if (t <= k) return mk(0, 1, t == 1, 0, 0, 0, 0);
        if (t == k + 1) return mk(0, 1, 0, 1, 1, 0, 0);
        if (t == k + 2) return mk(0, 1, 0, 2, 1, 10, 0);
        u = t - (k + 3);
        if (u >= 66) return mk(1, 0, 0, 0, 0, 0, 0);
        if (u < 63) begin
            r = 9 - u / 7;
            p = u % 7;
        end else begin
            r = 0;
            p = u - 63;
        end
        case (p)
            0:       return mk(0, 1, 0, 3, 1, 0, 0);
            1:       return mk(0, 1, 0, 4, 1, 0, 0);
            2:       return mk(0, 1, 0, 2, 1, r, 0);
            default: return mk(0, 1, 0, 5, 1, 0, p - 3);
        endcase
    endfunction

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_a"}, obs_a, 13'd0);
        check({tag, "_b"}, obs_b, 13'd0);
    endtask

    task automatic gap(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            check_idle("idle_gap");
        end
    endtask

    // One run from IDLE. abort_t / reset_t (0 = unused) cut it short at that cycle;
    // otherwise START is held for `hold` DONE cycles and then dropped.
    task automatic run(input string name, input int abort_t, input int reset_t, input int hold);
        int          ld_cnt = 0;
        int          first_a = -1;
        int          first_b = -1;
        int          hold_cnt = 0;
        bit          ended = 0;
        logic [12:0] e;
        start = 1'b1;
        for (int t = 1; t <= 200 && !ended; t++) begin
            step();
            e = expect_at(KA, t);
            check({name, "_a"}, obs_a, e);
            check({name, "_b"}, obs_b, expect_at(KB, t));
            if (ld_a) ld_cnt++;
            if (done_a && first_a < 0) first_a = t;
            if (done_b && first_b < 0) first_b = t;
            if (t == reset_t) begin
                RESET = 1'b1;
                step();
                check_idle({name, "_rst1"});
                step();
                check_idle({name, "_rst2"});
                RESET = 1'b0;
                start = 1'b0;
                step();
                check_idle({name, "_post_rst"});
                ended = 1;
            end else if (t == abort_t) begin
                start = 1'b0;
                step();
                check_idle({name, "_abort"});
                step();
                check_idle({name, "_abort_hold"});
                ended = 1;
            end else if (e[12]) begin
                hold_cnt++;
                if (hold_cnt >= hold) begin
                    start = 1'b0;
                    step();
                    check_idle({name, "_release"});
                    ended = 1;
                end
            end
        end
        if (abort_t == 0 && reset_t == 0) begin
            check_int({name, "_latency_a"}, first_a, KA + 69);
            check_int({name, "_latency_b"}, first_b, KB + 69);
            check_int({name, "_ld_pulses"}, ld_cnt, 68);
        end else begin
            check_int({name, "_no_done_a"}, first_a, -1);
        end
    endtask

    initial begin
        RESET = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("reset_state");
        end
        RESET = 1'b0;
        gap(2);

        run("nominal", 0, 0, 20);
        gap(1);
        run("rerun", 0, 0, 1);
        gap(2);
        // Round 5 InvMixColumns, column 2.
        run("abort_r5_mix2", KA + 3 + 33, 0, 0);
        gap(1);
        run("reset_mid", 0, 40, 0);
        gap(1);

        for (int i = 0; i < 4; i++) begin
            run("rand_abort", int'($urandom_range(80, 1)), 0, 0);
            gap(int'($urandom_range(4, 1)));
        end
        run("rand_full", 0, 0, int'($urandom_range(20, 1)));
        gap(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
